// File: rtl/rf_bypass_sb_if.sv
// Bus between decode/writeback and the rf_bypass_sb register file.
// Decode drives read selects and reservations; writeback drives writes.
interface rf_bypass_sb_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int NREAD  = 2
);
  logic [NREAD*ADDR_W-1:0] readregsel;
  logic [NREAD*DATA_W-1:0] readdata;
  logic [NREAD-1:0]        readbusy;
  logic [ADDR_W-1:0]       writeregsel;
  logic [DATA_W-1:0]       writedata;
  logic                    write;
  logic                    reserve;
  logic [ADDR_W-1:0]       reserveregsel;
  logic                    err;

  modport master (
    output readregsel, writeregsel, writedata, write, reserve, reserveregsel,
    input  readdata, readbusy, err
  );

  modport slave (
    input  readregsel, writeregsel, writedata, write, reserve, reserveregsel,
    output readdata, readbusy, err
  );
endinterface

// File: rtl/rf_bypass_sb.sv
// Parametrised bypassing register file with per-register busy scoreboard.
// Optional ZERO_REG_EN: register 0 is hardwired zero and never tracked.
module rf_bypass_sb #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int NREAD  = 2
) (
  input logic           clk,
  input logic           rst,
  rf_bypass_sb_if.slave bus
);
  localparam int NREG = 2**ADDR_W;

  logic [DATA_W-1:0] mem [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_next;
  logic              err_q;
  logic              err_next;
  logic              wr_en;
  logic              rsv_en;

`ifdef ZERO_REG_EN
  assign wr_en  = bus.write   && (bus.writeregsel   != '0);
  assign rsv_en = bus.reserve && (bus.reserveregsel != '0);
`else
  assign wr_en  = bus.write;
  assign rsv_en = bus.reserve;
`endif

  // Reserve is applied after the clear so a same-cycle reserve wins.
  always_comb begin
    busy_next = busy;
    err_next  = rsv_en && busy[bus.reserveregsel] &&
                !(wr_en && (bus.writeregsel == bus.reserveregsel));
    if (wr_en)
      busy_next[bus.writeregsel] = 1'b0;
    if (rsv_en)
      busy_next[bus.reserveregsel] = 1'b1;
`ifdef ZERO_REG_EN
    busy_next[0] = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++)
        mem[r] <= '0;
      busy  <= '0;
      err_q <= 1'b0;
    end else begin
      if (wr_en)
        mem[bus.writeregsel] <= bus.writedata;
      busy  <= busy_next;
      err_q <= err_next;
    end
  end

  assign bus.err = err_q;

  for (genvar i = 0; i < NREAD; i++) begin : g_read
    logic [ADDR_W-1:0] sel;
    logic              hit;

    assign sel = bus.readregsel[i*ADDR_W +: ADDR_W];
    assign hit = wr_en && (bus.writeregsel == sel);

`ifdef ZERO_REG_EN
    assign bus.readdata[i*DATA_W +: DATA_W] =
      (sel == '0) ? '0 : (hit ? bus.writedata : mem[sel]);
    assign bus.readbusy[i] = (sel != '0) && busy[sel] && !hit;
`else
    assign bus.readdata[i*DATA_W +: DATA_W] = hit ? bus.writedata : mem[sel];
    assign bus.readbusy[i] = busy[sel] && !hit;
`endif
  end
endmodule

// File: tb/tb_rf_bypass_sb.sv
// Directed self-checking bench for rf_bypass_sb (default and 32/4/3 builds).
module tb_rf_bypass_sb;
  logic clk;
  logic rst;
  int   checks;
  int   passes;

  rf_bypass_sb_if #(.DATA_W(16), .ADDR_W(3), .NREAD(2)) bus ();
  rf_bypass_sb_if #(.DATA_W(32), .ADDR_W(4), .NREAD(3)) wbus ();

  rf_bypass_sb #(.DATA_W(16), .ADDR_W(3), .NREAD(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  rf_bypass_sb #(.DATA_W(32), .ADDR_W(4), .NREAD(3)) dut_wide (
    .clk (clk),
    .rst (rst),
    .bus (wbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.write = 1'b0;  bus.reserve = 1'b0;
    bus.writeregsel = '0; bus.writedata = '0; bus.reserveregsel = '0;
    bus.readregsel = '0;
    wbus.write = 1'b0; wbus.reserve = 1'b0;
    wbus.writeregsel = '0; wbus.writedata = '0; wbus.reserveregsel = '0;
    wbus.readregsel = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    bus.readregsel = {3'd5, 3'd5};
    #1;
    if (bus.readdata !== 32'h0)
      $display("[TB] FAIL reset_readdata got %h want %h", bus.readdata, 32'h0);
    else passes++;
    checks++;
    if (bus.readbusy !== 2'b00)
      $display("[TB] FAIL reset_readbusy got %b want %b", bus.readbusy, 2'b00);
    else passes++;
    checks++;
    if (bus.err !== 1'b0)
      $display("[TB] FAIL reset_err got %b want %b", bus.err, 1'b0);
    else passes++;
    checks++;
  endtask

  task automatic test_write_bypass();
    bus.write = 1'b1; bus.writeregsel = 3'd3; bus.writedata = 16'hBEEF;
    bus.readregsel = {3'd5, 3'd3};
    #1;
    if (bus.readdata[15:0] !== 16'hBEEF)
      $display("[TB] FAIL bypass_rd0 got %h want %h", bus.readdata[15:0], 16'hBEEF);
    else passes++;
    checks++;
    if (bus.readdata[31:16] !== 16'h0000)
      $display("[TB] FAIL bypass_rd1 got %h want %h", bus.readdata[31:16], 16'h0000);
    else passes++;
    checks++;
    tick();
    bus.write = 1'b0;
    #1;
    if (bus.readdata[15:0] !== 16'hBEEF)
      $display("[TB] FAIL stored_rd0 got %h want %h", bus.readdata[15:0], 16'hBEEF);
    else passes++;
    checks++;
    tick();
  endtask

  task automatic test_scoreboard();
    bus.reserve = 1'b1; bus.reserveregsel = 3'd4;
    bus.readregsel = {3'd3, 3'd4};
    #1;
    if (bus.readbusy[0] !== 1'b0)
      $display("[TB] FAIL sb_same_cycle_reserve got %b want %b", bus.readbusy[0], 1'b0);
    else passes++;
    checks++;
    tick();
    bus.reserve = 1'b0;
    #1;
    if (bus.readbusy[0] !== 1'b1)
      $display("[TB] FAIL sb_busy_after_reserve got %b want %b", bus.readbusy[0], 1'b1);
    else passes++;
    checks++;
    tick();
    bus.write = 1'b1; bus.writeregsel = 3'd4; bus.writedata = 16'h1234;
    #1;
    if (bus.readbusy[0] !== 1'b0)
      $display("[TB] FAIL sb_write_resolves got %b want %b", bus.readbusy[0], 1'b0);
    else passes++;
    checks++;
    if (bus.readdata[15:0] !== 16'h1234)
      $display("[TB] FAIL sb_write_bypass got %h want %h", bus.readdata[15:0], 16'h1234);
    else passes++;
    checks++;
    tick();
    bus.write = 1'b0;
    #1;
    if (bus.readbusy[0] !== 1'b0)
      $display("[TB] FAIL sb_cleared got %b want %b", bus.readbusy[0], 1'b0);
    else passes++;
    checks++;
    if (bus.readdata[15:0] !== 16'h1234)
      $display("[TB] FAIL sb_stored got %h want %h", bus.readdata[15:0], 16'h1234);
    else passes++;
    checks++;
    tick();
  endtask

  task automatic test_reserve_write_same();
    bus.reserve = 1'b1; bus.reserveregsel = 3'd6;
    bus.readregsel = {3'd0, 3'd6};
    tick();
    bus.write = 1'b1; bus.writeregsel = 3'd6; bus.writedata = 16'h00AA;
    #1;
    if (bus.readbusy[0] !== 1'b0)
      $display("[TB] FAIL rw_same_bypass_busy got %b want %b", bus.readbusy[0], 1'b0);
    else passes++;
    checks++;
    tick();
    bus.write = 1'b0; bus.reserve = 1'b0;
    #1;
    if (bus.readbusy[0] !== 1'b1)
      $display("[TB] FAIL rw_same_busy got %b want %b", bus.readbusy[0], 1'b1);
    else passes++;
    checks++;
    if (bus.readdata[15:0] !== 16'h00AA)
      $display("[TB] FAIL rw_same_data got %h want %h", bus.readdata[15:0], 16'h00AA);
    else passes++;
    checks++;
    if (bus.err !== 1'b0)
      $display("[TB] FAIL rw_same_err got %b want %b", bus.err, 1'b0);
    else passes++;
    checks++;
    tick();
  endtask

  task automatic test_double_reserve();
    bus.reserve = 1'b1; bus.reserveregsel = 3'd2;
    bus.readregsel = {3'd0, 3'd2};
    tick();
    if (bus.err !== 1'b0)
      $display("[TB] FAIL dbl_first_err got %b want %b", bus.err, 1'b0);
    else passes++;
    checks++;
    tick();
    bus.reserve = 1'b0;
    #1;
    if (bus.err !== 1'b1)
      $display("[TB] FAIL dbl_err_high got %b want %b", bus.err, 1'b1);
    else passes++;
    checks++;
    if (bus.readbusy[0] !== 1'b1)
      $display("[TB] FAIL dbl_busy got %b want %b", bus.readbusy[0], 1'b1);
    else passes++;
    checks++;
    tick();
    if (bus.err !== 1'b0)
      $display("[TB] FAIL dbl_err_one_cycle got %b want %b", bus.err, 1'b0);
    else passes++;
    checks++;
    if (bus.readbusy[0] !== 1'b1)
      $display("[TB] FAIL dbl_busy_held got %b want %b", bus.readbusy[0], 1'b1);
    else passes++;
    checks++;
  endtask

  task automatic test_back_to_back_err();
    bus.reserve = 1'b1; bus.reserveregsel = 3'd5;
    bus.readregsel = {3'd5, 3'd5};
    tick();
    tick();
    if (bus.err !== 1'b1)
      $display("[TB] FAIL b2b_err_first got %b want %b", bus.err, 1'b1);
    else passes++;
    checks++;
    tick();
    bus.reserve = 1'b0;
    #1;
    if (bus.err !== 1'b1)
      $display("[TB] FAIL b2b_err_second got %b want %b", bus.err, 1'b1);
    else passes++;
    checks++;
    tick();
    if (bus.err !== 1'b0)
      $display("[TB] FAIL b2b_err_drop got %b want %b", bus.err, 1'b0);
    else passes++;
    checks++;
  endtask

  task automatic test_zero_reg();
    bus.write = 1'b1; bus.writeregsel = 3'd0; bus.writedata = 16'hFFFF;
    bus.readregsel = {3'd0, 3'd0};
    #1;
`ifdef ZERO_REG_EN
    if (bus.readdata[15:0] !== 16'h0000)
      $display("[TB] FAIL zero_bypass got %h want %h", bus.readdata[15:0], 16'h0000);
    else passes++;
    checks++;
`else
    if (bus.readdata[15:0] !== 16'hFFFF)
      $display("[TB] FAIL r0_bypass got %h want %h", bus.readdata[15:0], 16'hFFFF);
    else passes++;
    checks++;
`endif
    tick();
    bus.write = 1'b0;
    bus.reserve = 1'b1; bus.reserveregsel = 3'd0;
    tick();
    tick();
    bus.reserve = 1'b0;
    #1;
`ifdef ZERO_REG_EN
    if (bus.readdata[15:0] !== 16'h0000)
      $display("[TB] FAIL zero_stored got %h want %h", bus.readdata[15:0], 16'h0000);
    else passes++;
    checks++;
    if (bus.readbusy[0] !== 1'b0)
      $display("[TB] FAIL zero_busy got %b want %b", bus.readbusy[0], 1'b0);
    else passes++;
    checks++;
    if (bus.err !== 1'b0)
      $display("[TB] FAIL zero_err got %b want %b", bus.err, 1'b0);
    else passes++;
    checks++;
`else
    if (bus.readdata[15:0] !== 16'hFFFF)
      $display("[TB] FAIL r0_stored got %h want %h", bus.readdata[15:0], 16'hFFFF);
    else passes++;
    checks++;
    if (bus.readbusy[0] !== 1'b1)
      $display("[TB] FAIL r0_busy got %b want %b", bus.readbusy[0], 1'b1);
    else passes++;
    checks++;
    if (bus.err !== 1'b1)
      $display("[TB] FAIL r0_err got %b want %b", bus.err, 1'b1);
    else passes++;
    checks++;
`endif
    tick();
  endtask

  task automatic test_wide();
    wbus.write = 1'b1; wbus.writeregsel = 4'd15; wbus.writedata = 32'hDEADBEEF;
    wbus.readregsel = 12'hFFF;
    #1;
    if (wbus.readdata !== {3{32'hDEADBEEF}})
      $display("[TB] FAIL wide_bypass got %h want %h", wbus.readdata, {3{32'hDEADBEEF}});
    else passes++;
    checks++;
    tick();
    wbus.write = 1'b0;
    #1;
    if (wbus.readdata !== {3{32'hDEADBEEF}})
      $display("[TB] FAIL wide_stored got %h want %h", wbus.readdata, {3{32'hDEADBEEF}});
    else passes++;
    checks++;
    if (wbus.readbusy !== 3'b000)
      $display("[TB] FAIL wide_busy got %b want %b", wbus.readbusy, 3'b000);
    else passes++;
    checks++;
    tick();
  endtask

  task automatic test_mid_reset();
    bus.write = 1'b1; bus.writeregsel = 3'd1; bus.writedata = 16'h5555;
    bus.reserve = 1'b1; bus.reserveregsel = 3'd1;
    bus.readregsel = {3'd2, 3'd1};
    tick();
    bus.write = 1'b0; bus.reserve = 1'b0;
    #1;
    if (bus.readbusy !== 2'b11)
      $display("[TB] FAIL mid_pre_busy got %b want %b", bus.readbusy, 2'b11);
    else passes++;
    checks++;
    if (bus.readdata[15:0] !== 16'h5555)
      $display("[TB] FAIL mid_pre_data got %h want %h", bus.readdata[15:0], 16'h5555);
    else passes++;
    checks++;
    rst = 1'b1;
    bus.write = 1'b1; bus.writeregsel = 3'd1; bus.writedata = 16'h7777;
    bus.reserve = 1'b1; bus.reserveregsel = 3'd3;
    #1;
    if (bus.readdata[15:0] !== 16'h7777)
      $display("[TB] FAIL mid_rst_bypass got %h want %h", bus.readdata[15:0], 16'h7777);
    else passes++;
    checks++;
    tick();
    rst = 1'b0;
    bus.write = 1'b0; bus.reserve = 1'b0;
    #1;
    if (bus.readdata[15:0] !== 16'h0000)
      $display("[TB] FAIL mid_reg1_cleared got %h want %h", bus.readdata[15:0], 16'h0000);
    else passes++;
    checks++;
    if (bus.readbusy !== 2'b00)
      $display("[TB] FAIL mid_busy_cleared got %b want %b", bus.readbusy, 2'b00);
    else passes++;
    checks++;
    if (bus.err !== 1'b0)
      $display("[TB] FAIL mid_err got %b want %b", bus.err, 1'b0);
    else passes++;
    checks++;
    bus.readregsel = {3'd6, 3'd3};
    #1;
    if (bus.readbusy !== 2'b00)
      $display("[TB] FAIL mid_other_busy got %b want %b", bus.readbusy, 2'b00);
    else passes++;
    checks++;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    $display("[TB] starting rf_bypass_sb directed tests");
    test_reset();
    test_write_bypass();
    test_scoreboard();
    test_reserve_write_same();
    test_double_reserve();
    test_back_to_back_err();
    test_zero_reg();
    test_wide();
    test_mid_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
